// File: rtl/chess_scan_ctrl_if.sv
// Evaluator request/result channel between the scan sequencer and the evaluator.
interface chess_scan_ctrl_if #(
  parameter int SCORE_W = 16
);
  logic               ev_valid;
  logic               ev_ready;
  logic [3:0]         ev_row;
  logic [3:0]         ev_col;
  logic               ev_player;
  logic               res_valid;
  logic [SCORE_W-1:0] res_score;

  modport master (
    output ev_valid,
    output ev_row,
    output ev_col,
    output ev_player,
    input  ev_ready,
    input  res_valid,
    input  res_score
  );

  modport slave (
    input  ev_valid,
    input  ev_row,
    input  ev_col,
    input  ev_player,
    output ev_ready,
    output res_valid,
    output res_score
  );
endinterface

// File: rtl/chess_scan_ctrl.sv
// Gobang scan sequencer: walks cells, scores empty ones, keeps the best.
// Option CHESS_SCAN_CENTER_TIE_EN: equal scores resolved toward centre.
module chess_scan_ctrl #(
  parameter int BOARD_N = 15,
  parameter int SCORE_W = 16,
  parameter int ADDR_W  = 8
) (
  input  logic               ACLK,
  input  logic               ARESET,
  input  logic               start,
  input  logic               abort,
  input  logic               player,
  output logic               busy,
  output logic               done,
  output logic               best_valid,
  output logic [3:0]         best_row,
  output logic [3:0]         best_col,
  output logic [SCORE_W-1:0] best_score,
  output logic               brd_rd_en,
  output logic [ADDR_W-1:0]  brd_addr,
  input  logic [1:0]         brd_data,
  chess_scan_ctrl_if.master  ev
);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_RD   = 3'd1;
  localparam logic [2:0] S_CHK  = 3'd2;
  localparam logic [2:0] S_REQ  = 3'd3;
  localparam logic [2:0] S_WAIT = 3'd4;
  localparam logic [2:0] S_DONE = 3'd5;

  localparam logic [3:0] LAST = 4'(BOARD_N - 1);

  logic [2:0]         state_q, state_d;
  logic [3:0]         row_q, row_d;
  logic [3:0]         col_q, col_d;
  logic               player_q, player_d;
  logic               found_q, found_d;
  logic [SCORE_W-1:0] max_q, max_d;
  logic [3:0]         mrow_q, mrow_d;
  logic [3:0]         mcol_q, mcol_d;
  logic               best_valid_q, best_valid_d;
  logic [3:0]         best_row_q, best_row_d;
  logic [3:0]         best_col_q, best_col_d;
  logic [SCORE_W-1:0] best_score_q, best_score_d;

  logic               last_cell;
  logic [3:0]         nxt_row;
  logic [3:0]         nxt_col;
  logic               take;

  assign last_cell = (row_q == LAST) && (col_q == LAST);
  assign nxt_col   = (col_q == LAST) ? 4'd0 : col_q + 4'd1;
  assign nxt_row   = (col_q == LAST) ? row_q + 4'd1 : row_q;

`ifdef CHESS_SCAN_CENTER_TIE_EN
  localparam logic [3:0] CTR = 4'(BOARD_N / 2);

  function automatic logic [4:0] ctr_dist(
    input logic [3:0] r,
    input logic [3:0] c
  );
    logic [3:0] dr;
    logic [3:0] dc;
    dr = (r > CTR) ? r - CTR : CTR - r;
    dc = (c > CTR) ? c - CTR : CTR - c;
    return {1'b0, dr} + {1'b0, dc};
  endfunction

  logic closer;
  assign closer = ctr_dist(row_q, col_q) < ctr_dist(mrow_q, mcol_q);
  assign take   = !found_q
                || (ev.res_score > max_q)
                || ((ev.res_score == max_q) && closer);
`else
  // Strictly greater: the first cell reaching a score keeps it.
  assign take = !found_q || (ev.res_score > max_q);
`endif

  always_comb begin
    state_d      = state_q;
    row_d        = row_q;
    col_d        = col_q;
    player_d     = player_q;
    found_d      = found_q;
    max_d        = max_q;
    mrow_d       = mrow_q;
    mcol_d       = mcol_q;
    best_valid_d = best_valid_q;
    best_row_d   = best_row_q;
    best_col_d   = best_col_q;
    best_score_d = best_score_q;

    unique case (state_q)
      S_IDLE: begin
        if (start && !abort) begin
          state_d  = S_RD;
          row_d    = 4'd0;
          col_d    = 4'd0;
          max_d    = '0;
          mrow_d   = 4'd0;
          mcol_d   = 4'd0;
          found_d  = 1'b0;
          player_d = player;
        end
      end
      S_RD: state_d = S_CHK;
      S_CHK: begin
        if (brd_data == 2'b00) begin
          state_d = S_REQ;
        end else if (last_cell) begin
          state_d = S_DONE;
        end else begin
          state_d = S_RD;
          row_d   = nxt_row;
          col_d   = nxt_col;
        end
      end
      S_REQ: begin
        if (ev.ev_ready) state_d = S_WAIT;
      end
      S_WAIT: begin
        if (ev.res_valid) begin
          if (take) begin
            max_d  = ev.res_score;
            mrow_d = row_q;
            mcol_d = col_q;
          end
          found_d = 1'b1;
          if (last_cell) begin
            state_d = S_DONE;
          end else begin
            state_d = S_RD;
            row_d   = nxt_row;
            col_d   = nxt_col;
          end
        end
      end
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    if (abort && (state_q != S_IDLE)) state_d = S_IDLE;

    // Results land on entry to DONE so they coincide with the done pulse.
    if ((state_d == S_DONE) && (state_q != S_DONE)) begin
      best_valid_d = found_d;
      best_row_d   = found_d ? mrow_d : 4'd0;
      best_col_d   = found_d ? mcol_d : 4'd0;
      best_score_d = found_d ? max_d : '0;
    end
  end

  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      state_q      <= S_IDLE;
      row_q        <= 4'd0;
      col_q        <= 4'd0;
      player_q     <= 1'b0;
      found_q      <= 1'b0;
      max_q        <= '0;
      mrow_q       <= 4'd0;
      mcol_q       <= 4'd0;
      best_valid_q <= 1'b0;
      best_row_q   <= 4'd0;
      best_col_q   <= 4'd0;
      best_score_q <= '0;
    end else begin
      state_q      <= state_d;
      row_q        <= row_d;
      col_q        <= col_d;
      player_q     <= player_d;
      found_q      <= found_d;
      max_q        <= max_d;
      mrow_q       <= mrow_d;
      mcol_q       <= mcol_d;
      best_valid_q <= best_valid_d;
      best_row_q   <= best_row_d;
      best_col_q   <= best_col_d;
      best_score_q <= best_score_d;
    end
  end

  assign busy         = (state_q != S_IDLE);
  assign done         = (state_q == S_DONE);
  assign best_valid   = best_valid_q;
  assign best_row     = best_row_q;
  assign best_col     = best_col_q;
  assign best_score   = best_score_q;
  assign brd_rd_en    = (state_q == S_RD);
  assign brd_addr     = ADDR_W'(row_q) * ADDR_W'(BOARD_N) + ADDR_W'(col_q);
  assign ev.ev_valid  = (state_q == S_REQ);
  assign ev.ev_row    = row_q;
  assign ev.ev_col    = col_q;
  assign ev.ev_player = player_q;

endmodule

// File: tb/tb_chess_scan_ctrl.sv
// Bench for chess_scan_ctrl: board/evaluator models plus a done-result scoreboard.
module tb_chess_scan_ctrl;
  localparam int N     = 15;
  localparam int SW    = 16;
  localparam int AW    = 8;
  localparam int CELLS = N * N;

  logic          ACLK = 1'b0;
  logic          ARESET = 1'b0;
  logic          start = 1'b0;
  logic          abort = 1'b0;
  logic          player = 1'b0;
  logic          busy, done, best_valid;
  logic [3:0]    best_row, best_col;
  logic [SW-1:0] best_score;
  logic          brd_rd_en;
  logic [AW-1:0] brd_addr;
  logic [1:0]    brd_data = 2'b00;

  chess_scan_ctrl_if #(.SCORE_W(SW)) ev_if();

  chess_scan_ctrl #(.BOARD_N(N), .SCORE_W(SW), .ADDR_W(AW)) dut (
    .ACLK       (ACLK),
    .ARESET     (ARESET),
    .start      (start),
    .abort      (abort),
    .player     (player),
    .busy       (busy),
    .done       (done),
    .best_valid (best_valid),
    .best_row   (best_row),
    .best_col   (best_col),
    .best_score (best_score),
    .brd_rd_en  (brd_rd_en),
    .brd_addr   (brd_addr),
    .brd_data   (brd_data),
    .ev         (ev_if)
  );

  always #5 ACLK = ~ACLK;

  int cyc = 0;
  always @(posedge ACLK) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  function automatic void chk(string nm, longint act, longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s got %0d want %0d", nm, act, exp);
    end
  endfunction

  // Board RAM and evaluator models
  logic [1:0]    board  [CELLS];
  logic [SW-1:0] scores [CELLS];
  bit            model_en = 1'b1;
  bit            stray_rv = 1'b0;
  int            stall = 0;
  bit            hs_pend = 1'b0;
  logic [3:0]    hs_r, hs_c;
  int            hs_cnt = 0;
  bit            hold = 1'b0;
  logic [3:0]    h_r, h_c;
  int            stab_err = 0;
  int            ply_err = 0;
  bit            exp_player = 1'b0;

  initial begin
    ev_if.ev_ready  = 1'b1;
    ev_if.res_valid = 1'b0;
    ev_if.res_score = '0;
  end

  always @(negedge ACLK) begin
    if (ARESET) begin
      hs_pend         = 1'b0;
      hold            = 1'b0;
      ev_if.res_valid = 1'b0;
      ev_if.ev_ready  = 1'b1;
    end else if (!model_en) begin
      ev_if.res_valid = stray_rv;
      ev_if.res_score = 16'd999;
    end else begin
      if (brd_rd_en) brd_data = board[brd_addr];
      ev_if.res_valid = 1'b0;
      if (hs_pend) begin
        ev_if.res_valid = 1'b1;
        ev_if.res_score = scores[int'(hs_r) * N + int'(hs_c)];
        hs_pend = 1'b0;
      end
      if (hold && !ev_if.ev_valid) stab_err++;
      if (ev_if.ev_valid) begin
        if (ev_if.ev_player !== exp_player) ply_err++;
        if (hold && (ev_if.ev_row !== h_r || ev_if.ev_col !== h_c)) stab_err++;
        if (stall > 0) begin
          ev_if.ev_ready = 1'b0;
          stall--;
          hold = 1'b1;
          h_r  = ev_if.ev_row;
          h_c  = ev_if.ev_col;
        end else begin
          ev_if.ev_ready = 1'b1;
          hs_pend = 1'b1;
          hs_r    = ev_if.ev_row;
          hs_c    = ev_if.ev_col;
          hs_cnt++;
          hold = 1'b0;
        end
      end else begin
        ev_if.ev_ready = 1'b1;
        hold = 1'b0;
      end
    end
  end

  // Scoreboard
  typedef struct {
    bit            v;
    logic [3:0]    r;
    logic [3:0]    c;
    logic [SW-1:0] s;
    int            lat;
  } exp_t;

  exp_t q[$];
  int   t0 = 0;

  function automatic exp_t mk(bit v, int r, int c, int s, int lat);
    exp_t e;
    e.v   = v;
    e.r   = 4'(r);
    e.c   = 4'(c);
    e.s   = SW'(s);
    e.lat = lat;
    return e;
  endfunction

  always @(negedge ACLK) begin
    if (!ARESET && done) begin
      if (q.size() == 0) begin
        chk("unexpected_done", 1, 0);
      end else begin
        exp_t e;
        e = q.pop_front();
        chk("best_valid", best_valid, e.v);
        chk("best_row", best_row, e.r);
        chk("best_col", best_col, e.c);
        chk("best_score", best_score, e.s);
        chk("done_latency", cyc - t0, e.lat);
      end
    end
  end

  task automatic fill(logic [1:0] v, int s);
    for (int i = 0; i < CELLS; i++) begin
      board[i]  = v;
      scores[i] = SW'(s);
    end
  endtask

  task automatic go(bit ply);
    @(negedge ACLK);
    player     = ply;
    exp_player = ply;
    start      = 1'b1;
    t0         = cyc;
    @(negedge ACLK);
    start = 1'b0;
  endtask

  task automatic wait_idle(string nm);
    int n = 0;
    while ((q.size() != 0 || busy) && n < 3000) begin
      @(negedge ACLK);
      n++;
    end
    chk(nm, (n < 3000) ? 1 : 0, 1);
  endtask

  int h0;
  int er, ec;

  initial begin
    #1 ARESET = 1'b1;
    repeat (2) @(negedge ACLK);
    ARESET = 1'b0;
    @(negedge ACLK);
    chk("reset_outputs",
        {busy, done, best_valid, best_row, best_col, best_score,
         brd_rd_en, brd_addr, ev_if.ev_valid, ev_if.ev_row,
         ev_if.ev_col, ev_if.ev_player}, 0);

    // Empty board, constant score
`ifdef CHESS_SCAN_CENTER_TIE_EN
    er = 7; ec = 7;
`else
    er = 0; ec = 0;
`endif
    fill(2'b00, 5);
    h0 = hs_cnt;
    q.push_back(mk(1, er, ec, 5, 901));
    go(1'b1);
    wait_idle("empty_finish");
    chk("empty_handshakes", hs_cnt - h0, 225);

    // Fully occupied board
    fill(2'b01, 9);
    for (int i = 0; i < CELLS; i += 2) board[i] = 2'b10;
    h0 = hs_cnt;
    q.push_back(mk(0, 0, 0, 0, 451));
    go(1'b0);
    wait_idle("full_finish");
    chk("full_handshakes", hs_cnt - h0, 0);

    // Two empty cells
    fill(2'b01, 0);
    board[3 * N + 9]  = 2'b00;
    scores[3 * N + 9] = 16'd40;
    board[12 * N + 1] = 2'b00;
    scores[12 * N + 1] = 16'd41;
    h0 = hs_cnt;
    q.push_back(mk(1, 12, 1, 41, 455));
    go(1'b1);
    wait_idle("two_finish");
    chk("two_handshakes", hs_cnt - h0, 2);

    // Evaluator stalls the first request
    fill(2'b10, 0);
    board[2]  = 2'b00;
    scores[2] = 16'd7;
    stall     = 10;
    stab_err  = 0;
    q.push_back(mk(1, 0, 2, 7, 463));
    go(1'b0);
    wait_idle("stall_finish");
    chk("stall_stable", stab_err, 0);
    chk("stall_consumed", stall, 0);

    // Abort mid-scan
    fill(2'b00, 5);
    go(1'b1);
    repeat (198) @(negedge ACLK);
    abort = 1'b1;
    @(negedge ACLK);
    abort = 1'b0;
    chk("abort_busy", busy, 0);
    chk("abort_ev_valid", ev_if.ev_valid, 0);
    chk("abort_best",
        {best_valid, best_row, best_col, best_score},
        {1'b1, 4'd0, 4'd2, 16'd7});
    repeat (3) @(negedge ACLK);

    // Abort beats start in IDLE
    @(negedge ACLK);
    start = 1'b1;
    abort = 1'b1;
    @(negedge ACLK);
    start = 1'b0;
    abort = 1'b0;
    chk("abort_wins_start", busy, 0);

    // Restart after abort
    fill(2'b01, 0);
    board[3 * N + 9]  = 2'b00;
    scores[3 * N + 9] = 16'd40;
    board[12 * N + 1] = 2'b00;
    scores[12 * N + 1] = 16'd41;
    q.push_back(mk(1, 12, 1, 41, 455));
    go(1'b0);
    wait_idle("restart_finish");

    // Asynchronous reset in WAIT
    h0 = hs_cnt;
    go(1'b1);
    begin
      int n = 0;
      while (hs_cnt == h0 && n < 1000) begin
        @(negedge ACLK);
        n++;
      end
      chk("reach_wait", (n < 1000) ? 1 : 0, 1);
    end
    @(posedge ACLK);
    #2 ARESET = 1'b1;
    #1;
    chk("async_reset_outputs",
        {busy, done, best_valid, best_row, best_col, best_score,
         brd_rd_en, ev_if.ev_valid, ev_if.ev_row, ev_if.ev_col,
         ev_if.ev_player}, 0);
    @(negedge ACLK);
    @(negedge ACLK);
    ARESET   = 1'b0;
    model_en = 1'b0;
    stray_rv = 1'b1;
    @(negedge ACLK);
    stray_rv = 1'b0;
    @(negedge ACLK);
    @(negedge ACLK);
    chk("stray_res_ignored",
        {busy, done, best_valid, best_score}, 0);
    model_en = 1'b1;

    chk("scoreboard_drained", q.size(), 0);
    chk("player_driven", ply_err, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog got timeout want finish");
    $fatal(1);
  end
endmodule

// File: doc/chess_scan_ctrl.md
# chess_scan_ctrl

Sequencer for the Gobang move evaluator. On a start pulse it walks every board cell in row-major order and reads occupancy from the board RAM. For each empty cell it hands the coordinate to the chess-value evaluator over a valid/ready handshake, collects the returned score and tracks the highest-scoring cell. It sits between the AXI-Lite register block, which drives start, player and abort and reads the result, and the evaluator datapath / board RAM.

## Interface

Parameters:
- BOARD_N, 15, board edge length; cells = BOARD_N*BOARD_N.
- SCORE_W, 16, unsigned evaluator score width.
- ADDR_W, 8, board RAM address width; must satisfy 2**ADDR_W >= BOARD_N*BOARD_N.

Ports:
- ACLK  in  1  clock; all logic on rising edge.
- ARESET  in  1  asynchronous, active-high reset.
- start  in  1  single-cycle pulse; begins a scan when idle, ignored when busy.
- abort  in  1  synchronous abort; returns to IDLE, no done pulse.
- player  in  1  side to evaluate for; latched at accepted start.
- busy  out  1  high from the cycle after an accepted start until DONE is left.
- done  out  1  one-cycle pulse at scan completion.
- best_valid  out  1  at least one empty cell was scored in the last completed scan.
- best_row  out  4  row of best cell.
- best_col  out  4  column of best cell.
- best_score  out  SCORE_W  score of best cell.
- brd_rd_en  out  1  board RAM read strobe.
- brd_addr  out  ADDR_W  board RAM address, row*BOARD_N+col.
- brd_data  in  2  cell contents; 00 = empty, 01 = black, 10 = white; valid one cycle after brd_rd_en.
- ev_valid  out  1  evaluation request.
- ev_ready  in  1  evaluator accepts the request.
- ev_row  out  4  row of the request.
- ev_col  out  4  column of the request.
- ev_player  out  1  latched player.
- res_valid  in  1  evaluator result strobe.
- res_score  in  SCORE_W  evaluator result.

## Operation

- States: IDLE, RD, CHK, REQ, WAIT, DONE.
- IDLE: when start is seen, clear the cursor to (0,0), clear the running max and the found flag, latch player, go to RD.
- RD: assert brd_rd_en with the cursor address, go to CHK.
- CHK: sample brd_data. If empty, go to REQ. If occupied, advance the cursor and go to RD, or go to DONE if the cursor was the last cell.
- REQ: hold ev_valid and ev_row/ev_col/ev_player stable until ev_ready is sampled high, then go to WAIT.
- WAIT: when res_valid is seen, update the best cell if found is 0 or res_score > running max (strictly greater, so the first cell found wins ties), set found, then advance the cursor to RD or go to DONE.
- Cursor advance: col increments; when col = BOARD_N-1, col wraps to 0 and row increments. The last cell is (BOARD_N-1, BOARD_N-1).
- DONE: pulse done and copy the running best into the best_* outputs. best_valid = found; if found = 0, best_row/col/score = 0. Go to IDLE.
- best_* outputs keep their values until the next DONE; they are not cleared at start.
- res_valid outside WAIT is ignored. A start pulse outside IDLE is ignored.
- abort, in any non-IDLE state: next state is IDLE, ev_valid drops, best_* are unchanged, no done pulse. If abort and start arrive in the same cycle in IDLE, abort wins.

## Timing

- Reset values: every output is 0. State = IDLE, cursor = (0,0), running max = 0.
- Cycles from start to busy: 1 (start sampled in IDLE, RD on the next edge).
- Per occupied cell: 2 cycles (RD, CHK).
- Per empty cell with ev_ready already high and res_valid one cycle after acceptance: 4 cycles (RD, CHK, REQ, WAIT).
- Empty 15x15 board under those conditions: 900 scan cycles plus 1 DONE cycle.
- done and the best_* updates appear in the same cycle.
- ev_valid must never deassert without a handshake, except on abort or reset.
- ARESET asserted mid-scan forces the reset values immediately, independent of ACLK.

## Configuration

- CHESS_SCAN_CENTER_TIE_EN:
  - Defined: on equal scores, replace the current best if the new cell has a smaller Manhattan distance to the centre (BOARD_N/2, BOARD_N/2). Distance is computed combinationally in WAIT.
  - Undefined: first-found wins ties, as described above.

## Test plan

- Empty 15x15 board, evaluator always returns 5 -> done after 901 cycles, best_valid = 1, (0,0), score 5; with CHESS_SCAN_CENTER_TIE_EN -> (7,7).
- Fully occupied board -> no ev_valid ever asserted, done after 451 cycles, best_valid = 0, best_row/col/score = 0.
- Only (3,9) and (12,1) empty, scores 40 and 41 -> best (12,1), score 41; exactly 2 handshakes.
- ev_ready held low for 10 cycles at the first request -> ev_valid and ev_row/ev_col stay stable throughout; scan completes correctly afterwards.
- abort at cycle 200 -> busy drops next cycle, no done pulse, best_* unchanged. A new start then completes normally.
- ARESET pulse mid-WAIT -> all outputs 0 immediately. A stray res_valid afterwards is ignored.
